// File: rtl/timebin_pkg.sv
// Shared definitions for the time-bin run sequencer.
//   CNT_W                 - default photon-count width
//   CLKS_PER_UNIT_DEFAULT - default clocks per bin unit (100 us at 50 MHz)
//   state_e               - sequencer FSM states
package timebin_pkg;

    localparam int unsigned CNT_W                 = 16;
    localparam int unsigned CLKS_PER_UNIT_DEFAULT = 5000;

    typedef enum logic [1:0] {
        StIdle,
        StArm,
        StCount,
        StDrain
    } state_e;

endpackage

// File: rtl/start_edge_sync.sv
// Two-flop synchronizer plus falling-edge detector for the raw start button.
//   clk, rst_n - clock and asynchronous active-low reset
//   start_n    - raw active-low button, asynchronous to clk
//   start_evt  - one-cycle pulse on a synchronized 1->0 transition
module start_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic start_n,
    output logic start_evt
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // All flops reset to the released level so a press held through reset,
    // or a glitch during reset, cannot produce an event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= start_n;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    always_comb begin
        start_evt = prev_q & ~sync_q;
    end

endmodule

// File: rtl/timebin_run_sequencer.sv
// Time-bin run sequencer: splits a run into fixed-length bins, clears the
// external photon counter at every bin boundary and hands each captured count
// to a downstream sender over valid/ready.
//   clk, rst_n            - clock and asynchronous active-low reset
//   start_n               - raw active-low start button
//   abort                 - synchronous run abort (level)
//   bin_factor, num_bins  - bin length in units, bins per run (0 = free-run)
//   pmt_count, cnt_clear  - external counter value and its clear pulse
//   bin_data, bin_valid,
//   bin_ready             - captured-count handoff
//   running, done         - run in progress, normal completion pulse
//   overrun, cfg_err      - sticky: bin dropped, start with bin_factor==0
//   bin_index             - bins completed in the current run
module timebin_run_sequencer #(
    parameter int unsigned CLKS_PER_UNIT = timebin_pkg::CLKS_PER_UNIT_DEFAULT,
    parameter int unsigned CNT_W         = timebin_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_n,
    input  logic             abort,
    input  logic [7:0]       bin_factor,
    input  logic [15:0]      num_bins,
    input  logic [CNT_W-1:0] pmt_count,
    output logic             cnt_clear,
    output logic [CNT_W-1:0] bin_data,
    output logic             bin_valid,
    input  logic             bin_ready,
    output logic             running,
    output logic             done,
    output logic             overrun,
    output logic             cfg_err,
    output logic [15:0]      bin_index
);

    import timebin_pkg::*;

    state_e      state_q;
    logic [7:0]  bf_q;
    logic [15:0] nb_q;
    logic [31:0] timer_q;
    logic [31:0] bin_len;
    logic        last_tick;
    logic [15:0] next_index;
    logic        start_evt;

    start_edge_sync u_start_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_n   (start_n),
        .start_evt (start_evt)
    );

    always_comb begin
        bin_len    = 32'(bf_q) * CLKS_PER_UNIT;
        last_tick  = (timer_q == bin_len - 32'd1);
        next_index = bin_index + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            bf_q      <= 8'd0;
            nb_q      <= 16'd0;
            timer_q   <= 32'd0;
            cnt_clear <= 1'b0;
            bin_data  <= '0;
            bin_valid <= 1'b0;
            running   <= 1'b0;
            done      <= 1'b0;
            overrun   <= 1'b0;
            cfg_err   <= 1'b0;
            bin_index <= 16'd0;
        end else begin
            cnt_clear <= 1'b0;
            done      <= 1'b0;
            if (bin_valid && bin_ready) begin
                bin_valid <= 1'b0;
            end

            unique case (state_q)
                StIdle: begin
                    if (start_evt) begin
                        if (bin_factor == 8'd0) begin
                            cfg_err <= 1'b1;
                        end else begin
                            // Snapshot the config that was just validated so a
                            // change during ARM cannot yield a zero-length bin.
                            bf_q    <= bin_factor;
                            nb_q    <= num_bins;
                            running <= 1'b1;
                            state_q <= StArm;
                        end
                    end
                end

                StArm: begin
                    if (abort) begin
                        state_q   <= StIdle;
                        running   <= 1'b0;
                        bin_valid <= 1'b0;
                    end else begin
                        timer_q   <= 32'd0;
                        bin_index <= 16'd0;
                        overrun   <= 1'b0;
                        cfg_err   <= 1'b0;
                        cnt_clear <= 1'b1;
                        state_q   <= StCount;
                    end
                end

                StCount: begin
                    // Abort outranks a coincident boundary: no capture, no clear.
                    if (abort) begin
                        state_q   <= StIdle;
                        running   <= 1'b0;
                        bin_valid <= 1'b0;
                    end else if (last_tick) begin
                        timer_q   <= 32'd0;
                        cnt_clear <= 1'b1;
                        bin_index <= next_index;
                        if (!bin_valid || bin_ready) begin
                            bin_data  <= pmt_count;
                            bin_valid <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                        if (nb_q != 16'd0 && next_index == nb_q) begin
                            state_q <= StDrain;
                        end
                    end else begin
                        timer_q <= timer_q + 32'd1;
                    end
                end

                StDrain: begin
                    if (abort) begin
                        state_q   <= StIdle;
                        running   <= 1'b0;
                        bin_valid <= 1'b0;
                    end else if (!bin_valid) begin
                        done    <= 1'b1;
                        running <= 1'b0;
                        state_q <= StIdle;
                    end
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_timebin_run_sequencer.sv
module tb_timebin_run_sequencer;

    localparam int unsigned CPU = 4;
    localparam int unsigned CW  = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_n = 1'b1;
    logic          abort = 1'b0;
    logic [7:0]    bin_factor = 8'd0;
    logic [15:0]   num_bins = 16'd0;
    logic [CW-1:0] pmt_count = '0;
    logic          cnt_clear;
    logic [CW-1:0] bin_data;
    logic          bin_valid;
    logic          bin_ready = 1'b0;
    logic          running;
    logic          done;
    logic          overrun;
    logic          cfg_err;
    logic [15:0]   bin_index;

    int checks = 0;
    int errors = 0;
    logic [CW-1:0] exp_q[$];
    int cyc = 0;
    int last_clr = -1;
    int exp_spacing = 0;
    int done_cnt = 0;
    int inc = 1;
    int base;

    timebin_run_sequencer #(
        .CLKS_PER_UNIT (CPU),
        .CNT_W         (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_n    (start_n),
        .abort      (abort),
        .bin_factor (bin_factor),
        .num_bins   (num_bins),
        .pmt_count  (pmt_count),
        .cnt_clear  (cnt_clear),
        .bin_data   (bin_data),
        .bin_valid  (bin_valid),
        .bin_ready  (bin_ready),
        .running    (running),
        .done       (done),
        .overrun    (overrun),
        .cfg_err    (cfg_err),
        .bin_index  (bin_index)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // External photon counter: cleared by cnt_clear, otherwise adds inc per cycle.
    always @(negedge clk) begin
        if (cnt_clear) pmt_count = '0;
        else           pmt_count = pmt_count + CW'(inc);
    end

    // Monitor: scoreboard pops on each accepted beat; also tracks done and clear spacing.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bin_valid && bin_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 32'(bin_data), 32'hFFFF_FFFF);
                end else begin
                    check("beat_data", 32'(bin_data), 32'(exp_q.pop_front()));
                end
            end
            if (done) done_cnt++;
            if (cnt_clear) begin
                if (exp_spacing != 0 && last_clr >= 0)
                    check("clr_spacing", 32'(cyc - last_clr), 32'(exp_spacing));
                last_clr = cyc;
            end
        end
    end

    task automatic press_start();
        start_n = 1'b0;
        repeat (4) @(negedge clk);
        start_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_index(input logic [15:0] target, input int budget, input string name);
        int n = 0;
        while (bin_index != target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(bin_index), 32'(target));
    endtask

    task automatic wait_done(input int b, input int budget, input string name);
        int n = 0;
        while (done_cnt == b && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        check(name, 32'(done_cnt - b), 32'd1);
    endtask

    task automatic check_reset(input string p);
        check({p, "_cnt_clear"}, 32'(cnt_clear), 32'd0);
        check({p, "_bin_data"},  32'(bin_data),  32'd0);
        check({p, "_bin_valid"}, 32'(bin_valid), 32'd0);
        check({p, "_running"},   32'(running),   32'd0);
        check({p, "_done"},      32'(done),      32'd0);
        check({p, "_overrun"},   32'(overrun),   32'd0);
        check({p, "_cfg_err"},   32'(cfg_err),   32'd0);
        check({p, "_bin_index"}, 32'(bin_index), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check_reset("rst");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Normal run: L=8, 3 bins, each bin counts 7 cycles of inc=1.
        bin_factor = 8'd2; num_bins = 16'd3; bin_ready = 1'b1; inc = 1;
        exp_spacing = 8; last_clr = -1;
        repeat (3) exp_q.push_back(16'd7);
        base = done_cnt;
        press_start();
        bin_factor = 8'd5; num_bins = 16'd9;  // must be ignored mid-run
        wait_done(base, 200, "t1_done_once");
        check("t1_bin_index", 32'(bin_index), 32'd3);
        check("t1_running", 32'(running), 32'd0);
        check("t1_overrun", 32'(overrun), 32'd0);
        check("t1_queue_empty", 32'(exp_q.size()), 32'd0);

        // Backpressure: second bin dropped, first held until ready.
        bin_factor = 8'd2; num_bins = 16'd2; bin_ready = 1'b0; inc = 2;
        exp_spacing = 8; last_clr = -1;
        exp_q.push_back(16'd14);
        base = done_cnt;
        press_start();
        wait_index(16'd2, 100, "t2_reach_2");
        check("t2_valid_held", 32'(bin_valid), 32'd1);
        check("t2_data_held", 32'(bin_data), 32'd14);
        check("t2_overrun", 32'(overrun), 32'd1);
        check("t2_running_drain", 32'(running), 32'd1);
        check("t2_no_done_yet", 32'(done_cnt - base), 32'd0);
        bin_ready = 1'b1;
        wait_done(base, 50, "t2_done_once");
        check("t2_overrun_sticky", 32'(overrun), 32'd1);
        check("t2_queue_empty", 32'(exp_q.size()), 32'd0);

        // bin_factor==0 rejected; next valid start clears cfg_err.
        bin_factor = 8'd0; num_bins = 16'd1; inc = 1;
        exp_spacing = 0;
        press_start();
        repeat (4) @(negedge clk);
        check("t3_cfg_err", 32'(cfg_err), 32'd1);
        check("t3_idle", 32'(running), 32'd0);
        bin_factor = 8'd1; exp_spacing = 4; last_clr = -1;
        exp_q.push_back(16'd3);
        base = done_cnt;
        press_start();
        check("t3_cfg_err_clr", 32'(cfg_err), 32'd0);
        check("t3_overrun_clr", 32'(overrun), 32'd0);
        check("t3_running", 32'(running), 32'd1);
        wait_done(base, 50, "t3_done_once");

        // Free-run, abort after 5 bins.
        bin_factor = 8'd1; num_bins = 16'd0; bin_ready = 1'b1; inc = 1;
        exp_spacing = 4; last_clr = -1;
        repeat (5) exp_q.push_back(16'd3);
        base = done_cnt;
        press_start();
        wait_index(16'd5, 100, "t4_reach_5");
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t4_running", 32'(running), 32'd0);
        check("t4_valid", 32'(bin_valid), 32'd0);
        repeat (4) @(negedge clk);
        check("t4_no_done", 32'(done_cnt - base), 32'd0);
        check("t4_bin_index", 32'(bin_index), 32'd5);
        check("t4_queue_empty", 32'(exp_q.size()), 32'd0);

        // Abort coincident with a boundary.
        exp_spacing = 4; last_clr = -1;
        exp_q.push_back(16'd3);
        press_start();
        wait_index(16'd1, 100, "t5_reach_1");
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t5_bin_index", 32'(bin_index), 32'd1);
        check("t5_cnt_clear", 32'(cnt_clear), 32'd0);
        check("t5_valid", 32'(bin_valid), 32'd0);
        check("t5_running", 32'(running), 32'd0);
        check("t5_queue_empty", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset mid-run with a held beat; start glitch during reset.
        bin_ready = 1'b0; exp_spacing = 4; last_clr = -1;
        press_start();
        wait_index(16'd1, 100, "t6_reach_1");
        check("t6_valid_before", 32'(bin_valid), 32'd1);
        exp_spacing = 0;
        #2 rst_n = 1'b0;
        #1 check_reset("t6");
        start_n = 1'b0;
        #3 start_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("t6_no_run", 32'(running), 32'd0);
        check("t6_index", 32'(bin_index), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/timebin_run_sequencer.md
TIMEBIN_RUN_SEQUENCER -- requirements
Module: timebin_run_sequencer

Interface
REQ-001 Parameter CLKS_PER_UNIT, default 5000, SHALL set clock cycles per bin unit (100 us at 50 MHz).
REQ-002 Parameter CNT_W, default 16, SHALL set the photon-count width.
REQ-003 clk  in  1  single clock; all logic on posedge clk.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 start_n  in  1  raw active-low start button, asynchronous to clk.
REQ-006 abort  in  1  synchronous run abort, level-sampled.
REQ-007 bin_factor  in  8  bin length in units; bin length L = bin_factor*CLKS_PER_UNIT cycles.
REQ-008 num_bins  in  16  bins per run; 0 = free-run until abort.
REQ-009 pmt_count  in  CNT_W  live count from the external photon counter.
REQ-010 cnt_clear  out  1  one-cycle clear pulse to the external counter.
REQ-011 bin_data  out  CNT_W  captured count of the completed bin.
REQ-012 bin_valid / bin_ready  out / in  1 / 1  valid-ready handoff to the UART sender.
REQ-013 running  out  1  high from ARM through DRAIN.
REQ-014 done  out  1  one-cycle pulse at normal run completion.
REQ-015 overrun  out  1  sticky flag: a completed bin was dropped.
REQ-016 cfg_err  out  1  sticky flag: start attempted with bin_factor==0.
REQ-017 bin_index  out  16  number of bins completed in the current run.

Function
REQ-018 start_n SHALL pass through a 2-flop synchronizer; a start event is a synchronized 1->0 transition.
REQ-019 FSM states SHALL be IDLE, ARM, COUNT, DRAIN.
REQ-020 IDLE + start event + bin_factor!=0 -> ARM; with bin_factor==0 -> stay IDLE, set cfg_err.
REQ-021 ARM SHALL last 1 cycle: latch bin_factor and num_bins, clear timer and bin_index, clear overrun and cfg_err, assert cnt_clear, go to COUNT.
REQ-022 Configuration-input changes after ARM SHALL be ignored until the next run.
REQ-023 In COUNT a 32-bit timer SHALL count 0..L-1. At timer==L-1 (boundary): timer<=0, cnt_clear<=1 for one cycle, bin_index<=bin_index+1 (wraps 0xFFFF->0).
REQ-024 At each boundary, bin period SHALL be exactly L cycles edge to edge of cnt_clear.
REQ-025 Boundary with bin_valid==0, or bin_valid&&bin_ready in the same cycle: bin_data<=pmt_count, bin_valid<=1 on the same edge.
REQ-026 Boundary with bin_valid&&!bin_ready: new count dropped, bin_data held, overrun<=1; the counter SHALL still be cleared.
REQ-027 bin_valid SHALL stay high with bin_data stable until sampled with bin_ready; it SHALL drop the cycle after acceptance unless reloaded per REQ-025.
REQ-028 When num_bins!=0 and the boundary makes bin_index==num_bins, COUNT -> DRAIN.
REQ-029 DRAIN SHALL wait until bin_valid==0, then pulse done for one cycle and go to IDLE.
REQ-030 abort high in ARM, COUNT or DRAIN -> IDLE next cycle; bin_valid<=0; no done pulse; overrun retained.
REQ-031 Start events outside IDLE SHALL be ignored.
REQ-032 A coincident abort and boundary SHALL favour abort: no capture, no cnt_clear.

Reset
REQ-033 rst_n low SHALL force: state IDLE, timer 0, cnt_clear 0, bin_data 0, bin_valid 0, running 0, done 0, overrun 0, cfg_err 0, bin_index 0, synchronizer flops 1.

Structure
REQ-034 Package timebin_pkg SHALL hold the FSM state enum, CNT_W, and the CLKS_PER_UNIT default.
REQ-035 Sub-module start_edge_sync SHALL implement the synchronizer and falling-edge detector.

Verification (bench: CLKS_PER_UNIT=4)
REQ-036 bin_factor=2, num_bins=3, bin_ready=1, pmt_count ramps -> cnt_clear spacing 8 cycles; 3 beats equal to pmt_count at each boundary; done one pulse; bin_index=3.
REQ-037 bin_ready=0 through two boundaries -> first bin held, overrun=1; after bin_ready=1 one beat accepted, DRAIN exits, done pulses.
REQ-038 bin_factor=0 + start -> stays IDLE, cfg_err=1, running=0; next start with bin_factor=1 clears cfg_err.
REQ-039 num_bins=0, abort after 5 bins -> IDLE next cycle, bin_valid=0, no done.
REQ-040 abort asserted on the boundary cycle -> no capture, no cnt_clear.
REQ-041 rst_n low mid-COUNT with bin_valid=1 -> all outputs at reset values asynchronously; start_n glitch shorter than 1 cycle during rst_n low -> no run.
